// File: rtl/aibcr3aux_osc_divchk_if.sv
// Status/control bundle of the aux oscillator divider checker.
// The master side drives the divided clock under test and the controls;
// the slave side (the checker) returns the measurement results.
interface aibcr3aux_osc_divchk_if #(
    parameter int WIN_LOG2 = 8
);
    logic                div_in;
    logic                en;
    logic                clr_err;
    logic                busy;
    logic                done;
    logic                pass;
    logic [WIN_LOG2-1:0] edge_cnt;
    logic                err_sticky;

    modport master (
        output div_in,
        output en,
        output clr_err,
        input  busy,
        input  done,
        input  pass,
        input  edge_cnt,
        input  err_sticky
    );

    modport slave (
        input  div_in,
        input  en,
        input  clr_err,
        output busy,
        output done,
        output pass,
        output edge_cnt,
        output err_sticky
    );
endinterface

// File: rtl/aibcr3aux_osc_divchk.sv
// Aux oscillator divider-ratio checker.
// div_in (nominally clkin/2^DIV_LOG2) is synchronised into clkin, its rising
// edges are counted over a 2^WIN_LOG2-cycle window and the count is checked
// against the expected band EXP +/- TOL. Windows repeat back to back while en
// stays high; the one-cycle DONE slot between windows still counts edges and
// credits them to the following window.
module aibcr3aux_osc_divchk #(
    parameter int WIN_LOG2 = 8,
    parameter int DIV_LOG2 = 3,
    parameter int TOL      = 1,
    parameter int SETTLE   = 4
) (
    input  logic                   clkin,
    input  logic                   irstb,
    aibcr3aux_osc_divchk_if.slave  bus,
    inout  wire                    vcc_aibcr3aux,
    inout  wire                    vss_aibcr3aux
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SETTLE  = 2'b01,
        ST_MEASURE = 2'b10,
        ST_DONE    = 2'b11
    } state_t;

    // Expected band, evaluated in 32 bits so a large TOL cannot wrap.
    localparam logic [31:0] EXP_CNT = 32'd1 << (WIN_LOG2 - DIV_LOG2);
    localparam logic [31:0] TOL_U   = 32'(TOL);
    localparam logic [31:0] BAND_LO = (EXP_CNT >= TOL_U) ? (EXP_CNT - TOL_U) : 32'd0;
    localparam logic [31:0] BAND_HI = EXP_CNT + TOL_U;

    localparam logic [WIN_LOG2-1:0] WIN_LAST    = {WIN_LOG2{1'b1}};
    localparam logic [WIN_LOG2-1:0] CNT_MAX     = {WIN_LOG2{1'b1}};
    localparam logic [WIN_LOG2-1:0] CNT_ONE     = WIN_LOG2'(1'b1);
    localparam logic [WIN_LOG2-1:0] SETTLE_LAST = WIN_LOG2'(SETTLE - 1);

    // True when a completed window count lies inside the accepted band.
    function automatic logic in_band(input logic [WIN_LOG2-1:0] cnt);
        logic [31:0] cnt_w;
        cnt_w = 32'(cnt);
        return (cnt_w >= BAND_LO) && (cnt_w <= BAND_HI);
    endfunction

    // Supply pins carry no logic; folded into one net so they are not dangling.
    wire unused_supply_s;
    assign unused_supply_s = vcc_aibcr3aux ^ vss_aibcr3aux;

    logic                s1_q, s2_q, s3_q;
    logic                rise_s;
    state_t              state_q, state_d;
    logic [WIN_LOG2-1:0] win_q, win_d;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [WIN_LOG2-1:0] cnt_next_s;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [WIN_LOG2-1:0] edge_q, edge_d;
    logic                err_q, err_d;

    // Two-flop synchroniser for the asynchronous divided clock plus an edge flop.
    always_ff @(posedge clkin or negedge irstb) begin
        if (!irstb) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= bus.div_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_s = s2_q & ~s3_q;

    // Running count including this cycle's edge, held at all-ones once full.
    always_comb begin
        if (rise_s && (cnt_q != CNT_MAX)) begin
            cnt_next_s = cnt_q + CNT_ONE;
        end else begin
            cnt_next_s = cnt_q;
        end
    end

    // Next-state logic: settle, measure, report, and the sticky error flag.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        edge_d  = edge_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                win_d = {WIN_LOG2{1'b0}};
                if (bus.en) begin
                    state_d = ST_SETTLE;
                    cnt_d   = {WIN_LOG2{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                // Edges are ignored here while the synchroniser fills.
                if (!bus.en) begin
                    state_d = ST_IDLE;
                end else if (win_q == SETTLE_LAST) begin
                    state_d = ST_MEASURE;
                    win_d   = {WIN_LOG2{1'b0}};
                    cnt_d   = {WIN_LOG2{1'b0}};
                end else begin
                    win_d   = win_q + CNT_ONE;
                end
            end
            ST_MEASURE: begin
                if (!bus.en) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_next_s;
                    if (win_q == WIN_LAST) begin
                        // Result registers load on entry so they are valid with done.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        edge_d  = cnt_next_s;
                        pass_d  = in_band(cnt_next_s);
                    end else begin
                        win_d   = win_q + CNT_ONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.en) begin
                    // No re-settle; an edge seen now opens the next window.
                    state_d = ST_MEASURE;
                    win_d   = {WIN_LOG2{1'b0}};
                    cnt_d   = {{(WIN_LOG2-1){1'b0}}, rise_s};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                win_d   = {WIN_LOG2{1'b0}};
                cnt_d   = {WIN_LOG2{1'b0}};
            end
        endcase

        // A failing result is asserted both on entry to DONE and throughout
        // the DONE cycle, so a clear landing on either edge loses to it.
        if ((done_d && !pass_d) || ((state_q == ST_DONE) && !pass_q)) begin
            err_d = 1'b1;
        end else if (bus.clr_err) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // FSM, window counter and running edge count.
    always_ff @(posedge clkin or negedge irstb) begin
        if (!irstb) begin
            state_q <= ST_IDLE;
            win_q   <= {WIN_LOG2{1'b0}};
            cnt_q   <= {WIN_LOG2{1'b0}};
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clkin or negedge irstb) begin
        if (!irstb) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            edge_q <= {WIN_LOG2{1'b0}};
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
            edge_q <= edge_d;
            err_q  <= err_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.edge_cnt   = edge_q;
    assign bus.err_sticky = err_q;

endmodule

// File: tb/tb_aibcr3aux_osc_divchk.sv
// Bench for the aux oscillator divider checker. A reference model records
// every div_in sample and, from the window schedule (settle, 2^WIN_LOG2
// measure cycles, one done cycle), computes each window's edge count as a sum
// over that history; results go into a scoreboard queue that a monitor drains
// when the checker reports.
module tb_aibcr3aux_osc_divchk;

    localparam int WIN_LOG2 = 8;
    localparam int DIV_LOG2 = 3;
    localparam int TOL      = 1;
    localparam int SETTLE   = 4;
    localparam int WIN      = 1 << WIN_LOG2;
    localparam int EXP      = 1 << (WIN_LOG2 - DIV_LOG2);
    localparam int LO       = (EXP >= TOL) ? EXP - TOL : 0;
    localparam int HI       = EXP + TOL;
    localparam int CNT_MAX  = WIN - 1;
    localparam int HLEN     = 16384;

    logic clkin = 1'b0;
    logic irstb = 1'b0;
    wire  vcc_w;
    wire  vss_w;
    assign vcc_w = 1'b1;
    assign vss_w = 1'b0;

    always #5 clkin = ~clkin;

    aibcr3aux_osc_divchk_if #(.WIN_LOG2(WIN_LOG2)) bus ();

    aibcr3aux_osc_divchk #(
        .WIN_LOG2(WIN_LOG2),
        .DIV_LOG2(DIV_LOG2),
        .TOL(TOL),
        .SETTLE(SETTLE)
    ) dut (
        .clkin(clkin),
        .irstb(irstb),
        .bus(bus),
        .vcc_aibcr3aux(vcc_w),
        .vss_aibcr3aux(vss_w)
    );

    typedef struct {
        int edge_n;
        int cnt;
        bit pass;
        bit err;
    } exp_t;

    exp_t sb_q[$];

    // Stimulus-owned controls.
    int mode      = 0;   // 0 stuck low, 1 stuck high, 2 square wave
    int period    = 8;
    int drop_req  = 0;
    int stim_to   = 0;
    bit fin_req   = 1'b0;

    // Model state.
    int cyc = 0;
    bit hist [0:HLEN-1];
    bit m_active = 1'b0, m_in_done = 1'b0, m_pass = 1'b0, m_err = 1'b0;
    int m_edge = 0, m_start = 0, m_end = 0, m_dedge = 0, m_done_total = 0;

    // Monitor state.
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_exp_done;
    exp_t mon_e;

    // Divided-clock generator: square wave with optional suppressed pulses.
    initial begin : gen
        int ph;
        int drop_done;
        bit supp;
        ph = 0;
        drop_done = 0;
        supp = 1'b0;
        bus.div_in = 1'b0;
        forever begin
            @(negedge clkin);
            ph = (ph + 1) % period;
            if (ph == 0) begin
                supp = (drop_done < drop_req);
                if (supp) drop_done = drop_done + 1;
            end
            if (mode == 0)      bus.div_in = 1'b0;
            else if (mode == 1) bus.div_in = 1'b1;
            else                bus.div_in = (ph < period / 2) && !supp;
        end
    end

    // Rising edges seen by the checker in the counted edges (s, e].
    // The synchroniser delays a sampled level by two edges.
    function automatic int window_count(input int s, input int e);
        int c = 0;
        for (int j = s + 1; j <= e; j++) begin
            if (hist[j-2] && !hist[j-3]) c++;
        end
        if (c > CNT_MAX) c = CNT_MAX;
        return c;
    endfunction

    // Reference model: window schedule and expected results per clock edge.
    always @(posedge clkin) begin : model
        int   c;
        exp_t e;
        cyc = cyc + 1;
        if (cyc < HLEN) hist[cyc] = irstb ? bus.div_in : 1'b0;
        if (!irstb) begin
            m_active  = 1'b0;
            m_in_done = 1'b0;
            m_pass    = 1'b0;
            m_err     = 1'b0;
            m_edge    = 0;
        end else begin
            if (bus.clr_err) m_err = 1'b0;
            if (m_in_done && !m_pass) m_err = 1'b1;
            if (!m_active) begin
                if (bus.en) begin
                    m_active = 1'b1;
                    m_start  = cyc + SETTLE;
                    m_end    = cyc + SETTLE + WIN;
                end
            end else if (m_in_done) begin
                m_in_done = 1'b0;
                if (bus.en) begin
                    m_start = m_dedge;
                    m_end   = m_dedge + WIN + 1;
                end else begin
                    m_active = 1'b0;
                end
            end else if (!bus.en) begin
                m_active = 1'b0;
            end else if (cyc == m_end) begin
                c = window_count(m_start, m_end);
                m_pass = (c >= LO) && (c <= HI);
                m_edge = c;
                if (!m_pass) m_err = 1'b1;
                m_in_done = 1'b1;
                m_dedge = cyc;
                m_done_total = m_done_total + 1;
                e.edge_n = cyc;
                e.cnt    = c;
                e.pass   = m_pass;
                e.err    = m_err;
                sb_q.push_back(e);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: scoreboard on done plus per-cycle status checks.
    always begin : monitor
        @(negedge clkin or negedge irstb);
        #1;
        if (!irstb) begin
            chk("rst_busy", int'(bus.busy), 0);
            chk("rst_done", int'(bus.done), 0);
            chk("rst_pass", int'(bus.pass), 0);
            chk("rst_edge_cnt", int'(bus.edge_cnt), 0);
            chk("rst_err", int'(bus.err_sticky), 0);
        end else begin
            mon_exp_done = 1'b0;
            while (sb_q.size() > 0 && sb_q[0].edge_n < cyc) void'(sb_q.pop_front());
            if (sb_q.size() > 0 && sb_q[0].edge_n == cyc) begin
                mon_e = sb_q.pop_front();
                mon_exp_done = 1'b1;
            end
            chk("done", int'(bus.done), int'(mon_exp_done));
            if (mon_exp_done) begin
                chk("win_edge_cnt", int'(bus.edge_cnt), mon_e.cnt);
                chk("win_pass", int'(bus.pass), int'(mon_e.pass));
                chk("win_err", int'(bus.err_sticky), int'(mon_e.err));
            end
            chk("busy", int'(bus.busy), int'(m_active));
            chk("edge_cnt", int'(bus.edge_cnt), m_edge);
            chk("pass", int'(bus.pass), int'(m_pass));
            chk("err_sticky", int'(bus.err_sticky), int'(m_err));
        end
        if (fin_req) begin
            chk("sb_leftover", sb_q.size(), 0);
            chk("stim_timeouts", stim_to, 0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clkin);
    endtask

    // Wait for n more model-predicted window completions, bounded.
    task automatic wait_done(input int n);
        int target;
        bit hit;
        target = m_done_total + n;
        hit = 1'b0;
        for (int i = 0; i < 600 * n; i++) begin
            @(negedge clkin);
            if (m_done_total >= target) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) stim_to = stim_to + 1;
    endtask

    // Stop one edge before the current window completes, bounded.
    task automatic wait_before_end();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clkin);
            if (m_active && !m_in_done && (cyc + 1 == m_end)) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) stim_to = stim_to + 1;
    endtask

    task automatic pulse_clr();
        bus.clr_err = 1'b1;
        cycles(1);
        bus.clr_err = 1'b0;
    endtask

    initial begin : stim
        bus.en = 1'b0;
        bus.clr_err = 1'b0;
        cycles(3);
        irstb = 1'b1;
        cycles(10);

        // Nominal /8, three back-to-back windows.
        mode = 2;
        period = 8;
        cycles(5);
        bus.en = 1'b1;
        wait_done(3);

        // Wrong ratio /4, then back to /8 with the error held.
        period = 4;
        wait_done(2);
        period = 8;
        wait_done(2);
        bus.en = 1'b0;
        cycles(5);
        pulse_clr();
        cycles(3);

        // Stuck low; clear lands in the DONE cycle of a failing window.
        mode = 0;
        cycles(10);
        bus.en = 1'b1;
        wait_done(1);
        bus.clr_err = 1'b1;
        bus.en = 1'b0;
        cycles(1);
        bus.clr_err = 1'b0;
        cycles(3);
        pulse_clr();
        cycles(3);

        // Stuck high; clear lands on the edge that completes the window.
        mode = 1;
        cycles(10);
        bus.en = 1'b1;
        wait_before_end();
        bus.clr_err = 1'b1;
        cycles(1);
        bus.clr_err = 1'b0;
        bus.en = 1'b0;
        cycles(3);
        pulse_clr();
        cycles(3);

        // Abort around measure cycle 100, then a full restart.
        mode = 2;
        period = 8;
        cycles(5);
        bus.en = 1'b1;
        cycles(SETTLE + 100);
        bus.en = 1'b0;
        cycles(20);
        bus.en = 1'b1;
        wait_done(1);
        bus.en = 1'b0;
        cycles(3);

        // Tolerance boundary: one dropped edge, then two.
        bus.en = 1'b1;
        cycles(100);
        drop_req = drop_req + 1;
        wait_done(1);
        bus.en = 1'b0;
        cycles(3);
        bus.en = 1'b1;
        cycles(100);
        drop_req = drop_req + 2;
        wait_done(1);
        bus.en = 1'b0;
        cycles(3);

        // Asynchronous reset mid-window with div_in toggling.
        bus.en = 1'b1;
        cycles(150);
        #2;
        irstb = 1'b0;
        cycles(3);
        bus.en = 1'b0;
        irstb = 1'b1;
        cycles(10);

        fin_req = 1'b1;
        cycles(5);
        $display("FAIL summary_not_reached: monitor did not close the run");
        $fatal(1);
    end

endmodule
